usb_buffer_arbiter: RTL and testbench
=====================================

USB_BUFFER_ARBITER -- requirements
Module: usb_buffer_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, word-address width of the shared USB packet buffer (256 words = 1024 bytes).
REQ-002 Parameter COUNT_WIDTH, default 16, width of the accepted-packet counter.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clk48  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 cpu_req  in  1  CPU access request, held until granted.
REQ-007 cpu_addr  in  ADDR_WIDTH  CPU word address.
REQ-008 cpu_wdata  in  32  CPU write data, byte lanes already aligned.
REQ-009 cpu_wstrb  in  4  CPU byte write enables; 4'b0000 means read.
REQ-010 cpu_gnt  out  1  CPU request accepted this cycle.
REQ-011 cpu_rvalid  out  1  CPU read data valid.
REQ-012 cpu_rdata  out  32  CPU read data.
REQ-013 usb_req, usb_addr, usb_wdata, usb_wstrb, usb_gnt, usb_rvalid, usb_rdata  in/in/in/in/out/out/out  1/ADDR_WIDTH/32/4/1/1/32  USB-engine port, same semantics as the CPU port.
REQ-014 ram_en  out  1  buffer access strobe.
REQ-015 ram_addr  out  ADDR_WIDTH  buffer word address.
REQ-016 ram_wdata  out  32  buffer write data.
REQ-017 ram_wstrb  out  4  buffer byte write enables.
REQ-018 ram_rdata  in  32  buffer read data, valid one cycle after ram_en with ram_wstrb == 0.
REQ-019 got_packet  in  1  one-cycle pulse: USB engine finished writing a packet.
REQ-020 handled_packet  in  1  one-cycle pulse: CPU finished with the packet.
REQ-021 packet_ready  out  1  buffer owned by CPU (drives the core's packet-ready input).
REQ-022 overrun  out  1  sticky: packet arrived while CPU owned the buffer.
REQ-023 overrun_clr  in  1  clears overrun.
REQ-024 packet_count  out  COUNT_WIDTH  accepted packets, wraps.

Function
REQ-025 Ownership FSM, two states: USB_OWN (reset), CPU_OWN; packet_ready = (state == CPU_OWN).
REQ-026 USB_OWN + got_packet -> CPU_OWN next cycle; packet_count increments.
REQ-027 CPU_OWN + handled_packet, no got_packet -> USB_OWN next cycle.
REQ-028 CPU_OWN + got_packet, no handled_packet -> remain CPU_OWN; overrun set; packet_count unchanged.
REQ-029 CPU_OWN + got_packet and handled_packet same cycle -> remain CPU_OWN; packet_count increments; overrun unchanged.
REQ-030 handled_packet in USB_OWN ignored.
REQ-031 overrun_clr clears overrun next cycle; simultaneous set condition wins (overrun stays 1).
REQ-032 packet_count wraps from all-ones to 0.
REQ-033 Eligibility: CPU always eligible; USB eligible only in USB_OWN (state at start of cycle).
REQ-034 Grant combinational, same cycle as req: single eligible requester granted immediately.
REQ-035 Both eligible and requesting -> round-robin: grant the port not granted last; last_grant register resets to CPU, so first tie goes to USB.
REQ-036 last_grant updates on every grant.
REQ-037 At most one of cpu_gnt/usb_gnt high per cycle; ram_en = cpu_gnt | usb_gnt; ram_addr/ram_wdata/ram_wstrb from granted port; zero when idle.
REQ-038 Granted read -> matching rvalid high exactly one cycle later, rdata = ram_rdata that cycle; rdata is 0 when rvalid low.
REQ-039 Writes produce no rvalid.
REQ-040 Ungranted request causes no RAM activity; requester holds request until granted.

Reset
REQ-041 rst_n low asynchronously forces: state USB_OWN, packet_ready 0, overrun 0, packet_count 0, last_grant CPU, rvalid both 0.
REQ-042 Read granted in the cycle reset asserts yields no rvalid after reset release.
REQ-043 gnt and ram_en held 0 while rst_n low.

Verification
REQ-044 Reset, CPU read addr 0x05 with ram_rdata = 0xDEADBEEF -> cpu_gnt same cycle, cpu_rvalid next cycle, cpu_rdata 0xDEADBEEF.
REQ-045 Both request continuously in USB_OWN -> grants alternate USB, CPU, USB, CPU; never both high.
REQ-046 got_packet pulse -> packet_ready 1, packet_count 1; usb_req held never granted; handled_packet -> packet_ready 0, pending USB request granted next cycle.
REQ-047 In CPU_OWN pulse got_packet -> overrun 1, count unchanged; overrun_clr -> 0; got_packet + handled_packet together -> stays CPU_OWN, count +1.
REQ-048 Preload packet_count via 65535 packets -> next packet wraps count to 0.
REQ-049 Assert rst_n low mid-read and in CPU_OWN -> all outputs reset values immediately, no stale rvalid.

Source files
------------

// File: rtl/usb_buffer_arbiter_if.sv
// Shared-buffer access bundle: CPU and USB-engine request ports plus the single RAM port.
// The arbiter takes the slave view; whoever drives requests and owns the RAM takes master.
interface usb_buffer_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 8
);
    logic                  cpu_req;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [31:0]           cpu_wdata;
    logic [3:0]            cpu_wstrb;
    logic                  cpu_gnt;
    logic                  cpu_rvalid;
    logic [31:0]           cpu_rdata;

    logic                  usb_req;
    logic [ADDR_WIDTH-1:0] usb_addr;
    logic [31:0]           usb_wdata;
    logic [3:0]            usb_wstrb;
    logic                  usb_gnt;
    logic                  usb_rvalid;
    logic [31:0]           usb_rdata;

    logic                  ram_en;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [31:0]           ram_wdata;
    logic [3:0]            ram_wstrb;
    logic [31:0]           ram_rdata;

    modport slave (
        input  cpu_req, cpu_addr, cpu_wdata, cpu_wstrb,
        input  usb_req, usb_addr, usb_wdata, usb_wstrb,
        input  ram_rdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        output usb_gnt, usb_rvalid, usb_rdata,
        output ram_en, ram_addr, ram_wdata, ram_wstrb
    );

    modport master (
        output cpu_req, cpu_addr, cpu_wdata, cpu_wstrb,
        output usb_req, usb_addr, usb_wdata, usb_wstrb,
        output ram_rdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        input  usb_gnt, usb_rvalid, usb_rdata,
        input  ram_en, ram_addr, ram_wdata, ram_wstrb
    );
endinterface

// File: rtl/usb_buffer_arbiter.sv
// Arbitrates CPU and USB-engine access to the shared packet buffer and tracks which side
// currently owns the buffer, counting accepted packets and flagging overruns.
module usb_buffer_arbiter #(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic                   clk48,
    input  logic                   rst_n,
    usb_buffer_arbiter_if.slave    bus,
    input  logic                   got_packet,
    input  logic                   handled_packet,
    input  logic                   overrun_clr,
    output logic                   packet_ready,
    output logic                   overrun,
    output logic [COUNT_WIDTH-1:0] packet_count
);

    typedef enum logic {StUsbOwn, StCpuOwn} own_e;

    own_e                   state_q, state_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   overrun_q, overrun_d;
    logic                   overrun_set;
    logic                   last_usb_q;
    logic                   cpu_rd_q, usb_rd_q;

    logic                   cpu_win, usb_win;
    logic [ADDR_WIDTH-1:0]  sel_addr;
    logic [31:0]            sel_wdata;
    logic [3:0]             sel_wstrb;

    // Grant: USB may only touch the buffer while it owns it; ties go to the port not served last.
    always_comb begin
        cpu_win = bus.cpu_req;
        usb_win = bus.usb_req & (state_q == StUsbOwn);
        if (cpu_win && usb_win) begin
            cpu_win = last_usb_q;
            usb_win = ~last_usb_q;
        end
        cpu_win = cpu_win & rst_n;
        usb_win = usb_win & rst_n;
    end

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wstrb = '0;
        if (cpu_win) begin
            sel_addr  = bus.cpu_addr;
            sel_wdata = bus.cpu_wdata;
            sel_wstrb = bus.cpu_wstrb;
        end else if (usb_win) begin
            sel_addr  = bus.usb_addr;
            sel_wdata = bus.usb_wdata;
            sel_wstrb = bus.usb_wstrb;
        end
    end

    assign bus.cpu_gnt    = cpu_win;
    assign bus.usb_gnt    = usb_win;
    assign bus.ram_en     = cpu_win | usb_win;
    assign bus.ram_addr   = sel_addr;
    assign bus.ram_wdata  = sel_wdata;
    assign bus.ram_wstrb  = sel_wstrb;
    assign bus.cpu_rvalid = cpu_rd_q;
    assign bus.usb_rvalid = usb_rd_q;
    assign bus.cpu_rdata  = cpu_rd_q ? bus.ram_rdata : 32'h0;
    assign bus.usb_rdata  = usb_rd_q ? bus.ram_rdata : 32'h0;

    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            last_usb_q <= 1'b0;
            cpu_rd_q   <= 1'b0;
            usb_rd_q   <= 1'b0;
        end else begin
            if (cpu_win) begin
                last_usb_q <= 1'b0;
            end else if (usb_win) begin
                last_usb_q <= 1'b1;
            end
            cpu_rd_q <= cpu_win & (bus.cpu_wstrb == 4'b0000);
            usb_rd_q <= usb_win & (bus.usb_wstrb == 4'b0000);
        end
    end

    // Ownership: a packet landing while the CPU still holds the buffer is an overrun unless
    // the CPU releases the old one in that same cycle, in which case the new one is accepted.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        overrun_set = 1'b0;
        unique case (state_q)
            StUsbOwn: begin
                if (got_packet) begin
                    state_d = StCpuOwn;
                    count_d = count_q + COUNT_WIDTH'(1);
                end
            end
            StCpuOwn: begin
                if (got_packet && handled_packet) begin
                    count_d = count_q + COUNT_WIDTH'(1);
                end else if (got_packet) begin
                    overrun_set = 1'b1;
                end else if (handled_packet) begin
                    state_d = StUsbOwn;
                end
            end
        endcase
        overrun_d = overrun_set | (overrun_q & ~overrun_clr);
    end

    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StUsbOwn;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    assign packet_ready = (state_q == StCpuOwn);
    assign overrun      = overrun_q;
    assign packet_count = count_q;

endmodule

// File: tb/tb_usb_buffer_arbiter.sv
// Randomized scoreboard bench for usb_buffer_arbiter: a behavioural RAM answers the buffer
// port, a reference model predicts grants, read data and packet-ownership state.
module tb_usb_buffer_arbiter;

    logic        clk48;
    logic        rst_n;
    logic        got_packet, handled_packet, overrun_clr;
    logic        packet_ready, overrun;
    logic [15:0] packet_count;

    usb_buffer_arbiter_if #(.ADDR_WIDTH(8)) bus ();

    usb_buffer_arbiter #(
        .ADDR_WIDTH (8),
        .COUNT_WIDTH(16)
    ) dut (
        .clk48         (clk48),
        .rst_n         (rst_n),
        .bus           (bus),
        .got_packet    (got_packet),
        .handled_packet(handled_packet),
        .overrun_clr   (overrun_clr),
        .packet_ready  (packet_ready),
        .overrun       (overrun),
        .packet_count  (packet_count)
    );

    initial begin
        clk48 = 1'b0;
        forever #5 clk48 = ~clk48;
    end

    int n_checks = 0;
    int n_fail   = 0;
    bit started  = 1'b0;

    // Behavioural buffer RAM and the model's own copy of what it should contain.
    logic [31:0] ram_mem [256];
    logic [31:0] m_mem   [256];
    logic [31:0] cpu_q [$];
    logic [31:0] usb_q [$];

    // Reference model of ownership / arbitration history.
    bit          m_cpu_own;
    bit          m_overrun;
    bit          m_last_cpu;
    logic [15:0] m_count;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cpu_own  = 1'b0;
        m_overrun  = 1'b0;
        m_last_cpu = 1'b1;
        m_count    = 16'h0;
        cpu_q.delete();
        usb_q.delete();
    endtask

    always @(posedge clk48) begin
        if (bus.ram_en) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.ram_wstrb[b]) ram_mem[bus.ram_addr][b*8 +: 8] <= bus.ram_wdata[b*8 +: 8];
            end
        end
        if (bus.ram_en && bus.ram_wstrb == 4'b0000) bus.ram_rdata <= ram_mem[bus.ram_addr];
        else bus.ram_rdata <= $urandom;
    end

    // Monitor: outputs only move on posedge, so sample on the falling edge.
    initial begin
        forever begin
            @(negedge clk48);
            if (rst_n && started) begin
                if (bus.cpu_rvalid) begin
                    if (cpu_q.size() == 0) check("cpu_rvalid_unexpected", 32'd1, 32'd0);
                    else check("cpu_rdata", bus.cpu_rdata, cpu_q.pop_front());
                end else begin
                    check("cpu_rdata_idle", bus.cpu_rdata, 32'h0);
                end
                if (bus.usb_rvalid) begin
                    if (usb_q.size() == 0) check("usb_rvalid_unexpected", 32'd1, 32'd0);
                    else check("usb_rdata", bus.usb_rdata, usb_q.pop_front());
                end else begin
                    check("usb_rdata_idle", bus.usb_rdata, 32'h0);
                end
                check("cpu_rvalid_missing", cpu_q.size(), 0);
                check("usb_rvalid_missing", usb_q.size(), 0);
                check("packet_ready", {31'b0, packet_ready}, {31'b0, m_cpu_own});
                check("overrun", {31'b0, overrun}, {31'b0, m_overrun});
                check("packet_count", {16'b0, packet_count}, {16'b0, m_count});
            end
        end
    end

    // Called at negedge+1 with inputs set; checks grants, advances the model one clock.
    task automatic step();
        bit          ec, eu;
        logic [7:0]  ea;
        logic [31:0] ed;
        logic [3:0]  es;
        #1;
        ec = bus.cpu_req;
        eu = bus.usb_req && !m_cpu_own;
        if (ec && eu) begin
            // Alternate: whoever was not served last goes now.
            if (m_last_cpu) ec = 1'b0;
            else eu = 1'b0;
        end
        ea = 8'h0;
        ed = 32'h0;
        es = 4'h0;
        if (ec) begin
            ea = bus.cpu_addr; ed = bus.cpu_wdata; es = bus.cpu_wstrb;
        end else if (eu) begin
            ea = bus.usb_addr; ed = bus.usb_wdata; es = bus.usb_wstrb;
        end
        check("cpu_gnt", {31'b0, bus.cpu_gnt}, {31'b0, ec});
        check("usb_gnt", {31'b0, bus.usb_gnt}, {31'b0, eu});
        check("ram_en", {31'b0, bus.ram_en}, {31'b0, ec | eu});
        check("ram_addr", {24'b0, bus.ram_addr}, {24'b0, ea});
        check("ram_wdata", bus.ram_wdata, ed);
        check("ram_wstrb", {28'b0, bus.ram_wstrb}, {28'b0, es});
        if (ec || eu) begin
            m_last_cpu = ec;
            if (es == 4'b0000) begin
                if (ec) cpu_q.push_back(m_mem[ea]);
                else usb_q.push_back(m_mem[ea]);
            end else begin
                for (int b = 0; b < 4; b++) if (es[b]) m_mem[ea][b*8 +: 8] = ed[b*8 +: 8];
            end
        end
        if (!m_cpu_own) begin
            if (got_packet) begin
                m_cpu_own = 1'b1;
                m_count++;
            end
            if (overrun_clr) m_overrun = 1'b0;
        end else if (got_packet && handled_packet) begin
            m_count++;
            if (overrun_clr) m_overrun = 1'b0;
        end else if (got_packet) begin
            m_overrun = 1'b1;
        end else begin
            if (handled_packet) m_cpu_own = 1'b0;
            if (overrun_clr) m_overrun = 1'b0;
        end
        @(negedge clk48);
        #1;
        if (ec) bus.cpu_req = 1'b0;
        if (eu) bus.usb_req = 1'b0;
        got_packet     = 1'b0;
        handled_packet = 1'b0;
        overrun_clr    = 1'b0;
    endtask

    task automatic cpu_read(input logic [7:0] a);
        bus.cpu_req = 1'b1; bus.cpu_addr = a; bus.cpu_wstrb = 4'h0; bus.cpu_wdata = 32'h0;
    endtask

    task automatic usb_read(input logic [7:0] a);
        bus.usb_req = 1'b1; bus.usb_addr = a; bus.usb_wstrb = 4'h0; bus.usb_wdata = 32'h0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cpu_gnt"}, {31'b0, bus.cpu_gnt}, 32'd0);
        check({tag, "_usb_gnt"}, {31'b0, bus.usb_gnt}, 32'd0);
        check({tag, "_ram_en"}, {31'b0, bus.ram_en}, 32'd0);
        check({tag, "_cpu_rvalid"}, {31'b0, bus.cpu_rvalid}, 32'd0);
        check({tag, "_usb_rvalid"}, {31'b0, bus.usb_rvalid}, 32'd0);
        check({tag, "_packet_ready"}, {31'b0, packet_ready}, 32'd0);
        check({tag, "_overrun"}, {31'b0, overrun}, 32'd0);
        check({tag, "_packet_count"}, {16'b0, packet_count}, 32'd0);
    endtask

    // Reset in the middle of traffic: buffer owned by CPU, overrun set, reads in flight.
    task automatic mid_reset();
        got_packet = 1'b1;
        step();
        got_packet = 1'b1;
        step();
        cpu_read(8'h03);
        step();
        cpu_read(8'h04);
        bus.usb_req = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        model_reset();
        bus.cpu_req = 1'b0;
        @(negedge clk48);
        #1;
        check_reset_outputs("midrst_hold");
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step();
    endtask

    initial begin
        rst_n = 1'b1;
        got_packet = 1'b0; handled_packet = 1'b0; overrun_clr = 1'b0;
        bus.cpu_req = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0; bus.cpu_wstrb = '0;
        bus.usb_req = 1'b0; bus.usb_addr = '0; bus.usb_wdata = '0; bus.usb_wstrb = '0;
        for (int i = 0; i < 256; i++) begin
            ram_mem[i] = $urandom;
            m_mem[i]   = ram_mem[i];
        end
        ram_mem[5] = 32'hDEADBEEF;
        m_mem[5]   = 32'hDEADBEEF;
        model_reset();

        #1;
        rst_n = 1'b0;
        cpu_read(8'h07);
        usb_read(8'h02);
        #2;
        check_reset_outputs("rst");
        @(negedge clk48);
        @(negedge clk48);
        #1;
        bus.cpu_req = 1'b0;
        bus.usb_req = 1'b0;
        rst_n   = 1'b1;
        started = 1'b1;

        // Single CPU read of the known word.
        cpu_read(8'h05);
        step();

        // Both hammering in USB_OWN: grants must alternate.
        for (int i = 0; i < 6; i++) begin
            if (!bus.cpu_req) cpu_read(8'(i));
            if (!bus.usb_req) usb_read(8'(i + 8));
            step();
        end

        // Ownership handover blocks USB until the CPU releases the buffer.
        got_packet = 1'b1;
        step();
        usb_read(8'h05);
        for (int i = 0; i < 3; i++) step();
        handled_packet = 1'b1;
        step();
        step();

        // Overrun, its clear, and simultaneous got+handled.
        got_packet = 1'b1;
        step();
        got_packet = 1'b1;
        step();
        overrun_clr = 1'b1;
        step();
        got_packet = 1'b1;
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b1;
        step();
        got_packet = 1'b1;
        handled_packet = 1'b1;
        step();
        handled_packet = 1'b1;
        step();

        // Drive the counter to all-ones, then one more packet must wrap it.
        got_packet = 1'b1;
        step();
        while (m_count != 16'hFFFF) begin
            got_packet = 1'b1;
            handled_packet = 1'b1;
            step();
        end
        check("pre_wrap_count", {16'b0, packet_count}, 32'h0000FFFF);
        got_packet = 1'b1;
        handled_packet = 1'b1;
        step();
        check("wrap_count", {16'b0, packet_count}, 32'h0);
        handled_packet = 1'b1;
        step();

        mid_reset();

        for (int i = 0; i < 1500; i++) begin
            if (i == 700) mid_reset();
            if (!bus.cpu_req && ($urandom_range(0, 1) == 1)) begin
                bus.cpu_req   = 1'b1;
                bus.cpu_addr  = 8'($urandom_range(0, 7));
                bus.cpu_wdata = $urandom;
                bus.cpu_wstrb = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom);
            end
            if (!bus.usb_req && ($urandom_range(0, 1) == 1)) begin
                bus.usb_req   = 1'b1;
                bus.usb_addr  = 8'($urandom_range(0, 7));
                bus.usb_wdata = $urandom;
                bus.usb_wstrb = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom);
            end
            got_packet     = ($urandom_range(0, 7) == 0);
            handled_packet = ($urandom_range(0, 3) == 0);
            overrun_clr    = ($urandom_range(0, 7) == 0);
            step();
        end

        bus.cpu_req = 1'b0;
        bus.usb_req = 1'b0;
        step();
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
